mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch requester and the data (load/store) requester of the 5-stage core. It uses a req/gnt handshake per requester and fixed priority to data, with an anti-starvation override for fetch. Only one transaction is outstanding at a time. It sits between fetch/MEM-stage logic and a single `memory` instance, replacing the separate imem/dmem instances.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
MEM_LATENCY, 1, cycles from issue to memory read data valid (legal range 1..7)
STARVE_LIMIT, 3, consecutive contested data grants before fetch gets priority (1..15)

Ports:
clk  in  1  clock
reset  in  1  reset
if_req_i  in  1  fetch request (read only)
if_addr_i  in  AWIDTH  fetch address
if_kill_i  in  1  discard in-flight fetch response (pipeline flush)
if_gnt_o  out  1  fetch request accepted this cycle
if_rsp_valid_o  out  1  fetch data valid
if_rsp_data_o  out  DWIDTH  fetch data
dm_req_i  in  1  data request
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  AWIDTH  data address
dm_wdata_i  in  DWIDTH  store data, pre-aligned
dm_wstrb_i  in  DWIDTH/8  byte strobes
dm_gnt_o  out  1  data request accepted this cycle
dm_rsp_valid_o  out  1  data transaction complete
dm_rsp_data_o  out  DWIDTH  load data (0 for stores)
mem_addr_o  out  AWIDTH  memory address
mem_wdata_o  out  DWIDTH  memory write data
mem_wstrb_o  out  DWIDTH/8  memory strobes
mem_ren_o  out  1  memory read enable
mem_wen_o  out  1  memory write enable
mem_rdata_i  in  DWIDTH  memory read data
busy_o  out  1  transaction in flight

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high and on the cycle after: state IDLE, latency counter 0, starve_cnt 0. Every output is 0.
- FSM has two states, IDLE and BUSY.
- IDLE, arbitration (combinational, same cycle):
  - Only one requester asserting req: it wins.
  - Both asserting: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - The winner's gnt_o is high for exactly this cycle. mem_addr_o, mem_wdata_o and mem_wstrb_o are driven from the winner.
  - mem_ren_o = winner is fetch, or data load. mem_wen_o = winner is data store.
  - For a fetch grant, mem_wdata_o = 0 and mem_wstrb_o = 0.
  - At the clock edge: go to BUSY; latch owner, is_write and kill_pending = 0; load counter = MEM_LATENCY.
- starve_cnt update on each grant:
  - Fetch granted: clear to 0.
  - Data granted while if_req_i is high: increment, saturating at STARVE_LIMIT.
  - Data granted while if_req_i is low: unchanged.
- BUSY:
  - gnt outputs are 0; mem_ren_o and mem_wen_o are 0; busy_o = 1.
  - The counter decrements each cycle. When the counter reads 1, that cycle is the response cycle.
- Response cycle:
  - owner = fetch and not killed: if_rsp_valid_o = 1 and if_rsp_data_o = mem_rdata_i, combinational pass-through.
  - owner = data: dm_rsp_valid_o = 1. dm_rsp_data_o = mem_rdata_i for a load, 0 for a store.
  - Next state is IDLE. No grant is issued in the response cycle.
  - Issue-to-issue throughput is therefore MEM_LATENCY + 1 cycles.
- rsp_data outputs are 0 whenever the matching rsp_valid is 0.
- Kill:
  - if_kill_i high in any cycle while owner = fetch in BUSY, or in the fetch grant cycle itself, sets kill_pending.
  - A killed fetch still consumes its latency, but if_rsp_valid_o stays 0.
  - if_kill_i has no effect on data transactions or while IDLE.
- Requester rules:
  - Requesters hold req and payload stable until gnt. The arbiter samples the payload only in the grant cycle.
  - Dropping req before gnt is legal and simply withdraws the request.
- Reset mid-transaction: abort, return to IDLE, no response pulse, starve_cnt cleared.
- Widths: the counter is 3 bits and starve_cnt is 4 bits, with no wrap in either. Addresses pass through unmodified.

Test Plan:
- Fetch only, MEM_LATENCY=1: if_req at 0x01000000 in cycle 0 → if_gnt cycle 0, mem_ren cycle 0; if_rsp_valid cycle 1 with data = mem_rdata_i; next grant no earlier than cycle 2.
- Simultaneous: both req in cycle 0, data store to 0x01000010, wstrb 4'b0011 → dm_gnt cycle 0, mem_wen=1, mem_wstrb=0011; dm_rsp_valid cycle 1 with data 0; if_gnt cycle 2.
- Starvation, STARVE_LIMIT=3: both requesters held high continuously → grant sequence D,D,D,F,D,D,D,F; starve_cnt returns to 0 after each F.
- Kill: fetch granted cycle 0 with MEM_LATENCY=3, if_kill_i pulsed in cycle 1 → if_rsp_valid stays 0 in cycles 1–3; busy_o high in cycles 1–3; next grant cycle 4.
- Load latency: MEM_LATENCY=2, data load granted cycle 0, memory returns 0xDEADBEEF in cycle 2 → dm_rsp_valid only in cycle 2 with 0xDEADBEEF.
- Reset mid-op: reset asserted cycle 1 of a MEM_LATENCY=3 fetch → no rsp pulses; all outputs 0 in cycles 2–3; fresh request after reset deasserts is granted immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that lets instruction fetch and data load/store share one single-ported memory.
// Data has fixed priority. Fetch wins after STARVE_LIMIT contested data grants. One transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [AWIDTH-1:0]     if_addr_i,
    input  logic                  if_kill_i,
    output logic                  if_gnt_o,
    output logic                  if_rsp_valid_o,
    output logic [DWIDTH-1:0]     if_rsp_data_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [AWIDTH-1:0]     dm_addr_i,
    input  logic [DWIDTH-1:0]     dm_wdata_i,
    input  logic [DWIDTH/8-1:0]   dm_wstrb_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rsp_valid_o,
    output logic [DWIDTH-1:0]     dm_rsp_data_o,
    output logic [AWIDTH-1:0]     mem_addr_o,
    output logic [DWIDTH-1:0]     mem_wdata_o,
    output logic [DWIDTH/8-1:0]   mem_wstrb_o,
    output logic                  mem_ren_o,
    output logic                  mem_wen_o,
    input  logic [DWIDTH-1:0]     mem_rdata_i,
    output logic                  busy_o
);
    localparam int unsigned CW  = 3;
    localparam int unsigned SCW = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic           owner_fetch_q, owner_fetch_d;
    logic           is_write_q, is_write_d;
    logic           kill_q, kill_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SCW-1:0] starve_q, starve_d;
    logic           grant_if, grant_dm;
    logic           starved;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_fetch_q <= 1'b0;
            is_write_q    <= 1'b0;
            kill_q        <= 1'b0;
            cnt_q         <= '0;
            starve_q      <= '0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            is_write_q    <= is_write_d;
            kill_q        <= kill_d;
            cnt_q         <= cnt_d;
            starve_q      <= starve_d;
        end
    end

    // Arbitration, next state and outputs. All outputs are forced to 0 while reset is high.
    always_comb begin
        state_d        = state_q;
        owner_fetch_d  = owner_fetch_q;
        is_write_d     = is_write_q;
        kill_d         = kill_q;
        cnt_d          = cnt_q;
        starve_d       = starve_q;
        grant_if       = 1'b0;
        grant_dm       = 1'b0;
        starved        = (starve_q == SCW'(STARVE_LIMIT));
        if_gnt_o       = 1'b0;
        if_rsp_valid_o = 1'b0;
        if_rsp_data_o  = '0;
        dm_gnt_o       = 1'b0;
        dm_rsp_valid_o = 1'b0;
        dm_rsp_data_o  = '0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_wstrb_o    = '0;
        mem_ren_o      = 1'b0;
        mem_wen_o      = 1'b0;
        busy_o         = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (dm_req_i && !(if_req_i && starved)) begin
                        grant_dm = 1'b1;
                    end else if (if_req_i) begin
                        grant_if = 1'b1;
                    end

                    if (grant_if) begin
                        if_gnt_o      = 1'b1;
                        mem_addr_o    = if_addr_i;
                        mem_ren_o     = 1'b1;
                        state_d       = BUSY;
                        owner_fetch_d = 1'b1;
                        is_write_d    = 1'b0;
                        kill_d        = if_kill_i;
                        cnt_d         = CW'(MEM_LATENCY);
                        starve_d      = '0;
                    end else if (grant_dm) begin
                        dm_gnt_o      = 1'b1;
                        mem_addr_o    = dm_addr_i;
                        mem_wdata_o   = dm_wdata_i;
                        mem_wstrb_o   = dm_wstrb_i;
                        mem_ren_o     = !dm_we_i;
                        mem_wen_o     = dm_we_i;
                        state_d       = BUSY;
                        owner_fetch_d = 1'b0;
                        is_write_d    = dm_we_i;
                        kill_d        = 1'b0;
                        cnt_d         = CW'(MEM_LATENCY);
                        if (if_req_i && !starved) begin
                            starve_d = starve_q + SCW'(1);
                        end
                    end
                end

                BUSY: begin
                    busy_o = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                    if (owner_fetch_q && if_kill_i) begin
                        kill_d = 1'b1;
                    end
                    // The counter reads 1 in the response cycle. A kill in that cycle still drops the response.
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        kill_d  = 1'b0;
                        if (owner_fetch_q) begin
                            if (!kill_q && !if_kill_i) begin
                                if_rsp_valid_o = 1'b1;
                                if_rsp_data_o  = mem_rdata_i;
                            end
                        end else begin
                            dm_rsp_valid_o = 1'b1;
                            dm_rsp_data_o  = is_write_q ? '0 : mem_rdata_i;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with MEM_LATENCY=3 and STARVE_LIMIT=3.
// Stimulus pushes the expected grant and response events. A negedge monitor pops them and compares.
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    localparam int K_IFG = 0, K_DMG = 1, K_IFR = 2, K_DMR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_i, if_kill_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [3:0]  dm_wstrb_i;
    logic        if_gnt_o, if_rsp_valid_o, dm_gnt_o, dm_rsp_valid_o;
    logic [31:0] if_rsp_data_o, dm_rsp_data_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ren_o, mem_wen_o, busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        ren;
        logic        wen;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    mem_port_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_gnt_o(if_gnt_o), .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_wstrb_i(dm_wstrb_i),
        .dm_gnt_o(dm_gnt_o), .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_data_o(dm_rsp_data_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int kind, input int c, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic ren, input logic wen);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.wdata = wd; e.wstrb = ws;
        e.ren = ren; e.wen = wen; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_rsp(input int kind, input int c, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = '0; e.wdata = '0; e.wstrb = '0;
        e.ren = 1'b0; e.wen = 1'b0; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{if_gnt_o, if_rsp_valid_o, if_rsp_data_o, dm_gnt_o, dm_rsp_valid_o, dm_rsp_data_o,
                 mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_ren_o, mem_wen_o, busy_o};
    endfunction

    task automatic chk_zero(input string name);
        #1;
        chk(name, 32'(any_out()), 32'd0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: at most one grant or response event can be present in any cycle
    always @(negedge clk) begin : monitor
        ev_t o;
        ev_t e;
        bit  seen;
        seen = 1'b0;
        o.addr = mem_addr_o; o.wdata = mem_wdata_o; o.wstrb = mem_wstrb_o;
        o.ren = mem_ren_o; o.wen = mem_wen_o; o.data = '0; o.cyc = cyc; o.kind = -1;
        total++;
        if ((!if_rsp_valid_o && if_rsp_data_o !== '0) || (!dm_rsp_valid_o && dm_rsp_data_o !== '0)
            || (if_gnt_o && dm_gnt_o)) begin
            bad++;
            $display("FAIL idle_outputs at cycle %0d: ifd=%h dmd=%h ifg=%b dmg=%b",
                     cyc, if_rsp_data_o, dm_rsp_data_o, if_gnt_o, dm_gnt_o);
        end
        if (if_gnt_o)            begin seen = 1'b1; o.kind = K_IFG; end
        else if (dm_gnt_o)       begin seen = 1'b1; o.kind = K_DMG; end
        else if (if_rsp_valid_o) begin seen = 1'b1; o.kind = K_IFR; o.data = if_rsp_data_o; end
        else if (dm_rsp_valid_o) begin seen = 1'b1; o.kind = K_DMR; o.data = dm_rsp_data_o; end
        if (seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event kind=%0d at cycle %0d addr=%h data=%h",
                         o.kind, cyc, o.addr, o.data);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != o.kind || e.cyc != o.cyc ||
                    ((o.kind == K_IFG || o.kind == K_DMG) &&
                     (e.addr !== o.addr || e.wdata !== o.wdata || e.wstrb !== o.wstrb ||
                      e.ren !== o.ren || e.wen !== o.wen)) ||
                    ((o.kind == K_IFR || o.kind == K_DMR) && e.data !== o.data)) begin
                    bad++;
                    $display("FAIL event got kind=%0d cyc=%0d addr=%h wd=%h ws=%h ren=%b wen=%b data=%h expected kind=%0d cyc=%0d addr=%h wd=%h ws=%h ren=%b wen=%b data=%h",
                             o.kind, o.cyc, o.addr, o.wdata, o.wstrb, o.ren, o.wen, o.data,
                             e.kind, e.cyc, e.addr, e.wdata, e.wstrb, e.ren, e.wen, e.data);
                end
            end
        end
    end

    initial begin
        int t0;
        reset = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h0100_0000; if_kill_i = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0100_0010;
        dm_wdata_i = 32'hFFFF_FFFF; dm_wstrb_i = 4'hF; mem_rdata_i = 32'h1234_5678;

        // While reset is held, outputs stay 0 even though both requests are raised.
        repeat (3) begin
            tick();
            chk_zero("reset_outputs");
        end
        tick();
        reset = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
        chk_zero("post_reset_outputs");

        // Fetch only: back-to-back requests are spaced by LAT+1 cycles.
        tick(); t0 = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h0100_0000; mem_rdata_i = 32'h1111_2222;
        push_gnt(K_IFG, t0, 32'h0100_0000, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_IFR, t0 + LAT, 32'h1111_2222);
        push_gnt(K_IFG, t0 + LAT + 1, 32'h0100_0004, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_IFR, t0 + 2*LAT + 1, 32'h1111_2222);
        tick(); if_addr_i = 32'h0100_0004;
        wait_until(t0 + LAT + 2); if_req_i = 1'b0;
        wait_until(t0 + 2*LAT + 2);

        // Simultaneous requests: data store wins, then fetch.
        t0 = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h0100_0020;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0100_0010;
        dm_wdata_i = 32'hA5A5_A5A5; dm_wstrb_i = 4'b0011; mem_rdata_i = 32'h1234_5678;
        push_gnt(K_DMG, t0, 32'h0100_0010, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b1);
        push_rsp(K_DMR, t0 + LAT, 32'h0);
        push_gnt(K_IFG, t0 + LAT + 1, 32'h0100_0020, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_IFR, t0 + 2*LAT + 1, 32'h1234_5678);
        tick(); dm_req_i = 1'b0;
        wait_until(t0 + LAT + 2); if_req_i = 1'b0;
        wait_until(t0 + 2*LAT + 2);

        // Starvation: with both requests held, grants follow the pattern D,D,D,F,D,D,D,F.
        t0 = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h0000_3000;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_2000;
        dm_wdata_i = 32'h0; dm_wstrb_i = 4'h0; mem_rdata_i = 32'hCAFE_0000;
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 3) begin
                push_gnt(K_IFG, t0 + k*(LAT+1), 32'h0000_3000, 32'h0, 4'h0, 1'b1, 1'b0);
                push_rsp(K_IFR, t0 + k*(LAT+1) + LAT, 32'hCAFE_0000);
            end else begin
                push_gnt(K_DMG, t0 + k*(LAT+1), 32'h0000_2000, 32'h0, 4'h0, 1'b1, 1'b0);
                push_rsp(K_DMR, t0 + k*(LAT+1) + LAT, 32'hCAFE_0000);
            end
        end
        wait_until(t0 + 7*(LAT+1) + 1); if_req_i = 1'b0; dm_req_i = 1'b0;
        wait_until(t0 + 8*(LAT+1));

        // Kill: a flushed fetch consumes its latency but produces no response.
        t0 = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h0000_4000; mem_rdata_i = 32'h5555_AAAA;
        push_gnt(K_IFG, t0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 1'b0);
        push_gnt(K_IFG, t0 + LAT + 1, 32'h0000_4004, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_IFR, t0 + 2*LAT + 1, 32'h5555_AAAA);
        tick(); if_kill_i = 1'b1; if_addr_i = 32'h0000_4004;
        #1; chk("kill_busy_c1", 32'(busy_o), 32'd1);
        tick(); if_kill_i = 1'b0;
        #1; chk("kill_busy_c2", 32'(busy_o), 32'd1);
        tick();
        #1; chk("kill_busy_c3", 32'(busy_o), 32'd1);
        tick();
        #1; chk("kill_busy_c4", 32'(busy_o), 32'd0);
        tick(); if_req_i = 1'b0;
        wait_until(t0 + 2*LAT + 2);

        // Load: read data is passed through only in the response cycle.
        t0 = cyc;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_5000;
        dm_wdata_i = 32'h0; dm_wstrb_i = 4'h0; mem_rdata_i = 32'h0;
        push_gnt(K_DMG, t0, 32'h0000_5000, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_DMR, t0 + LAT, 32'hDEAD_BEEF);
        tick(); dm_req_i = 1'b0;
        wait_until(t0 + LAT); mem_rdata_i = 32'hDEAD_BEEF;
        tick(); mem_rdata_i = 32'h0;

        // Reset mid-fetch: the fetch is aborted and a fresh request is granted at once.
        tick(); t0 = cyc;
        if_req_i = 1'b1; if_addr_i = 32'h0000_6000; mem_rdata_i = 32'h7777_7777;
        push_gnt(K_IFG, t0, 32'h0000_6000, 32'h0, 4'h0, 1'b1, 1'b0);
        tick(); if_req_i = 1'b0; reset = 1'b1;
        chk_zero("midop_reset_c1");
        tick(); reset = 1'b0;
        chk_zero("midop_reset_c2");
        tick();
        chk_zero("midop_reset_c3");
        tick(); if_req_i = 1'b1; if_addr_i = 32'h0000_6004;
        push_gnt(K_IFG, t0 + 4, 32'h0000_6004, 32'h0, 4'h0, 1'b1, 1'b0);
        push_rsp(K_IFR, t0 + 4 + LAT, 32'h7777_7777);
        tick(); if_req_i = 1'b0;
        wait_until(t0 + 4 + LAT + 3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
